// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, IR field positions and FSM states shared by the
// hardwired control sequencer and its register-select decoders.
package cpu_ctrl_pkg;

    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHL  = 5'd8;
    localparam logic [4:0] OP_ROR  = 5'd9;
    localparam logic [4:0] OP_ROL  = 5'd10;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED
    } state_t;

    typedef enum logic [2:0] {
        K_ALU, K_MULDIV, K_NOP, K_HALT, K_ILL
    } op_kind_t;

    function automatic op_kind_t op_kind(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: return K_ALU;
            OP_MUL, OP_DIV:                 return K_MULDIV;
            OP_NOP:                         return K_NOP;
            OP_HALT:                        return K_HALT;
            default:                        return K_ILL;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// reg_select_decoder: 4-bit register index to one-hot select vector,
// all zeros when disabled.
module reg_select_decoder #(
    parameter int NREG = 16
) (
    input  logic            i_en,
    input  logic [3:0]      i_sel,
    output logic [NREG-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) o_onehot[i_sel] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control FSM for the CPU datapath.
// Define CTRL_WAITSTATE_EN for the T1 memory wait counter and mem_fault.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NREG        = 16,
    parameter int OPW         = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            run,
    input  logic            stop,
    input  logic [31:0]     ir,
    input  logic            mem_ready,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            PCout,
    output logic            IncPC,
    output logic            MARin,
    output logic            memRead,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Zhighout,
    output logic            Zlowout,
    output logic            HIin,
    output logic            LOin,
    output logic [OPW-1:0]  alu_op,
    output logic            running,
    output logic            halted,
    output logic            illegal_op,
    output logic            mem_fault
);

    state_t         r_state;
    state_t         w_state_next;
    op_kind_t       w_kind;
    logic [OPW-1:0] w_op;
    logic [3:0]     w_ra;
    logic [3:0]     w_rb;
    logic [3:0]     w_rc;
    logic [3:0]     w_rout_sel;
    logic           w_rin_en;
    logic           w_rout_en;
    logic           w_end;
    logic           w_fault_set;
    logic           w_unused;

    assign w_op   = ir[OP_HI:OP_LO];
    assign w_ra   = ir[RA_HI:RA_LO];
    assign w_rb   = ir[RB_HI:RB_LO];
    assign w_rc   = ir[RC_HI:RC_LO];
    assign w_kind = op_kind(w_op);

`ifdef CTRL_WAITSTATE_EN
    localparam logic [3:0] TIMEOUT_CNT = 4'(MEM_TIMEOUT);

    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_inc;
    logic       r_mem_fault;

    assign w_wait_inc = r_wait_cnt + 4'd1;
    assign w_unused   = &{1'b0, ir[14:0]};

    // Counter is held at zero outside T1, so every T1 entry starts fresh.
    always_ff @(posedge clock) begin
        if (clear || r_state != T1) r_wait_cnt <= '0;
        else if (!mem_ready)        r_wait_cnt <= w_wait_inc;
    end

    always_ff @(posedge clock) begin
        if (clear)            r_mem_fault <= 1'b0;
        else if (w_fault_set) r_mem_fault <= 1'b1;
    end
`else
    assign w_unused = &{1'b0, ir[14:0], mem_ready, w_fault_set,
                        1'(MEM_TIMEOUT)};
`endif

    always_ff @(posedge clock) begin
        if (clear) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // All strobes are forced low while clear is high.
    always_comb begin
        w_state_next = r_state;
        w_end        = 1'b0;
        w_fault_set  = 1'b0;
        w_rin_en     = 1'b0;
        w_rout_en    = 1'b0;
        w_rout_sel   = w_rb;
        PCout        = 1'b0;
        IncPC        = 1'b0;
        MARin        = 1'b0;
        memRead      = 1'b0;
        MDRin        = 1'b0;
        MDRout       = 1'b0;
        IRin         = 1'b0;
        Yin          = 1'b0;
        Zin          = 1'b0;
        Zhighout     = 1'b0;
        Zlowout      = 1'b0;
        HIin         = 1'b0;
        LOin         = 1'b0;
        alu_op       = '0;
        running      = 1'b0;
        halted       = 1'b0;
        illegal_op   = 1'b0;
        mem_fault    = 1'b0;
        if (!clear) begin
            running = (r_state != IDLE) && (r_state != HALTED);
            halted  = (r_state == HALTED);
`ifdef CTRL_WAITSTATE_EN
            mem_fault = r_mem_fault;
`endif
            unique case (r_state)
                IDLE: if (run) w_state_next = T0;
                T0: begin
                    PCout        = 1'b1;
                    MARin        = 1'b1;
                    IncPC        = 1'b1;
                    w_state_next = T1;
                end
                T1: begin
                    memRead = 1'b1;
                    MDRin   = 1'b1;
`ifdef CTRL_WAITSTATE_EN
                    if (mem_ready) begin
                        w_state_next = T2;
                    end else if (w_wait_inc == TIMEOUT_CNT) begin
                        w_state_next = HALTED;
                        w_fault_set  = 1'b1;
                    end
`else
                    w_state_next = T2;
`endif
                end
                T2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                    if (w_kind == K_NOP)       w_end = 1'b1;
                    else if (w_kind == K_HALT) w_state_next = HALTED;
                    else                       w_state_next = T3;
                end
                T3: begin
                    if (w_kind == K_ILL) begin
                        illegal_op = 1'b1;
                        w_end      = 1'b1;
                    end else begin
                        w_rout_en    = 1'b1;
                        Yin          = 1'b1;
                        w_state_next = T4;
                    end
                end
                T4: begin
                    w_rout_en    = 1'b1;
                    w_rout_sel   = w_rc;
                    Zin          = 1'b1;
                    alu_op       = w_op;
                    w_state_next = T5;
                end
                T5: begin
                    Zlowout = 1'b1;
                    if (w_kind == K_MULDIV) begin
                        LOin         = 1'b1;
                        w_state_next = T6;
                    end else begin
                        w_rin_en = 1'b1;
                        w_end    = 1'b1;
                    end
                end
                T6: begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                    w_end    = 1'b1;
                end
                HALTED:  w_state_next = HALTED;
                default: w_state_next = IDLE;
            endcase
            if (w_end) w_state_next = stop ? IDLE : T0;
        end
    end

    reg_select_decoder #(.NREG(NREG)) u_rin_dec (
        .i_en     (w_rin_en),
        .i_sel    (w_ra),
        .o_onehot (Rin)
    );

    reg_select_decoder #(.NREG(NREG)) u_rout_dec (
        .i_en     (w_rout_en),
        .i_sel    (w_rout_sel),
        .o_onehot (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized instruction stream against a microstep
// table model, with a queue-based scoreboard checked every cycle.
module tb_control_sequencer;

    localparam int TMO = 15;

    logic        clock = 1'b0;
    logic        clear, run, stop, mem_ready;
    logic [31:0] ir;
    logic [15:0] Rin, Rout;
    logic        PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin;
    logic [4:0]  alu_op;
    logic        running, halted, illegal_op, mem_fault;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic pcout, incpc, marin, memread, mdrin, mdrout, irin;
        logic yin, zin, zhighout, zlowout, hiin, loin;
        logic [4:0] alu;
        logic running, halted, illegal, fault;
    } obs_t;

    obs_t  q[$];
    string qn[$];
    int    checks = 0;
    int    errors = 0;
    bit    fault_m = 0;
    bit    in_idle = 0;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .stop(stop), .ir(ir),
        .mem_ready(mem_ready), .Rin(Rin), .Rout(Rout), .PCout(PCout),
        .IncPC(IncPC), .MARin(MARin), .memRead(memRead), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin),
        .alu_op(alu_op), .running(running), .halted(halted),
        .illegal_op(illegal_op), .mem_fault(mem_fault)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic obs_t sample();
        obs_t a;
        a = {Rin, Rout, PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin,
             Yin, Zin, Zhighout, Zlowout, HIin, LOin, alu_op,
             running, halted, illegal_op, mem_fault};
        return a;
    endfunction

    always @(negedge clock) begin
        obs_t  e;
        obs_t  a;
        string n;
        if (q.size() > 0) begin
            e = q.pop_front();
            n = qn.pop_front();
            a = sample();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s got=%h exp=%h", n, a, e);
            end
        end
    end

    function automatic obs_t base();
        obs_t e;
        e = '0;
        e.fault = fault_m;
        return e;
    endfunction

    // 0 alu, 1 mul/div, 2 nop, 3 halt, 4 illegal
    function automatic int kind(input logic [4:0] op);
        if (op inside {[5'd3:5'd10]}) return 0;
        if (op == 5'd15 || op == 5'd16) return 1;
        if (op == 5'd26) return 2;
        if (op == 5'd27) return 3;
        return 4;
    endfunction

    task automatic step(input obs_t e, input string nm);
        q.push_back(e);
        qn.push_back(nm);
        @(posedge clock);
        #1;
    endtask

    task automatic noise();
        run       = 1'($urandom);
        stop      = 1'($urandom);
        mem_ready = 1'($urandom);
    endtask

    task automatic halt_phase();
        obs_t e;
        for (int i = 0; i < 20; i++) begin
            noise();
            e = base();
            e.halted = 1'b1;
            step(e, "HALTED");
        end
        clear = 1'b1;
        step('0, "clear_halted");
        clear   = 1'b0;
        run     = 1'b0;
        fault_m = 1'b0;
        in_idle = 1'b1;
    endtask

    task automatic fetch(input int waits, output bit to);
        obs_t e;
        int   n;
        to = 1'b0;
        e = base();
        e.running = 1'b1;
        e.pcout = 1'b1;
        e.marin = 1'b1;
        e.incpc = 1'b1;
        noise();
        step(e, "T0");
        e = base();
        e.running = 1'b1;
        e.memread = 1'b1;
        e.mdrin = 1'b1;
`ifdef CTRL_WAITSTATE_EN
        n = 0;
        forever begin
            noise();
            mem_ready = (n >= waits);
            step(e, "T1");
            if (mem_ready) break;
            n++;
            if (n == TMO) begin
                to = 1'b1;
                break;
            end
        end
`else
        n = waits;
        noise();
        step(e, "T1");
`endif
    endtask

    task automatic do_instr(input logic [31:0] word, input bit stp,
                            input int waits, input bit abort);
        obs_t       e;
        bit         to;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        int         k;
        if (in_idle) begin
            noise();
            run = 1'b1;
            step(base(), "IDLE_run");
        end
        in_idle = 1'b0;
        ir = word;
        op = word[31:27];
        ra = word[26:23];
        rb = word[22:19];
        rc = word[18:15];
        k  = kind(op);
        fetch(waits, to);
        if (to) begin
            fault_m = 1'b1;
            halt_phase();
            return;
        end
        e = base();
        e.running = 1'b1;
        e.mdrout = 1'b1;
        e.irin = 1'b1;
        noise();
        if (k == 2) stop = stp;
        step(e, "T2");
        if (k == 2) begin
            in_idle = stp;
            return;
        end
        if (k == 3) begin
            halt_phase();
            return;
        end
        e = base();
        e.running = 1'b1;
        noise();
        if (k == 4) begin
            e.illegal = 1'b1;
            stop = stp;
            step(e, "T3_illegal");
            in_idle = stp;
            return;
        end
        e.rout = 16'd1 << rb;
        e.yin = 1'b1;
        step(e, "T3");
        if (abort) begin
            noise();
            clear = 1'b1;
            step('0, "clear_T4");
            clear = 1'b0;
            run   = 1'b0;
            fault_m = 1'b0;
            step('0, "idle_after_clear");
            in_idle = 1'b1;
            return;
        end
        e = base();
        e.running = 1'b1;
        e.rout = 16'd1 << rc;
        e.zin = 1'b1;
        e.alu = op;
        noise();
        step(e, "T4");
        e = base();
        e.running = 1'b1;
        e.zlowout = 1'b1;
        noise();
        if (k == 0) begin
            e.rin = 16'd1 << ra;
            stop = stp;
            step(e, "T5_alu");
            in_idle = stp;
            return;
        end
        e.loin = 1'b1;
        step(e, "T5_lo");
        e = base();
        e.running = 1'b1;
        e.zhighout = 1'b1;
        e.hiin = 1'b1;
        noise();
        stop = stp;
        step(e, "T6_hi");
        in_idle = stp;
    endtask

    function automatic logic [31:0] rand_word(output bit stp);
        logic [4:0]  op;
        logic [31:0] w;
        int          r;
        r = $urandom_range(0, 19);
        if (r < 8)       op = 5'(3 + r);
        else if (r == 8) op = 5'd15;
        else if (r == 9) op = 5'd16;
        else if (r == 10) op = 5'd26;
        else if (r == 11) op = 5'd27;
        else begin
            op = 5'($urandom_range(0, 31));
            while (kind(op) != 4) op = 5'($urandom_range(0, 31));
        end
        w = $urandom;
        w[31:27] = op;
        stp = (op != 5'd26) && ($urandom_range(0, 3) == 0);
        return w;
    endfunction

    initial begin
        logic [31:0] w;
        bit          stp;
        clear     = 1'b1;
        run       = 1'b0;
        stop      = 1'b0;
        mem_ready = 1'b0;
        ir        = '0;
        @(posedge clock);
        #1;
        step('0, "reset0");
        run = 1'b1;
        step('0, "reset1");
        clear = 1'b0;
        run   = 1'b0;
        step('0, "idle_hold");
        in_idle = 1'b1;

        do_instr(32'h18918000, 1'b0, 0, 1'b0);
        do_instr(32'h18918000, 1'b0, 3, 1'b0);
        do_instr(32'h78228000, 1'b0, 0, 1'b0);
        do_instr(32'hF8000000, 1'b0, 1, 1'b0);
        do_instr(32'hD0000000, 1'b0, 0, 1'b0);
        do_instr(32'h18918000, 1'b1, 0, 1'b0);
        do_instr(32'h20000000 | 32'($urandom_range(0, 32'h07FFFFFF)),
                 1'b0, 2, 1'b1);
        do_instr(32'hD8000000, 1'b0, 0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            w = rand_word(stp);
            do_instr(w, stp, $urandom_range(0, 4), $urandom_range(0, 15) == 0);
        end

`ifdef CTRL_WAITSTATE_EN
        do_instr(32'h18918000, 1'b0, 100, 1'b0);
        do_instr(32'h18918000, 1'b0, TMO - 1, 1'b0);
`endif

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
